scan_tester: RTL and testbench
==============================

SCAN_TESTER -- requirements
Module: scan_tester

Interface
REQ-001 Parameter CHAIN_LEN, default 8: number of scan cells in the attached chain (>=2).
REQ-002 Parameter PI_W, default 4: primary-input width driven during capture.
REQ-003 Parameter PO_W, default 4: primary-output width checked during capture.
REQ-004 C  in  1  clock; all state updates on posedge C.
REQ-005 global_reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a test session; sampled in IDLE only.
REQ-007 vec_valid / vec_ready  in / out  1 / 1  vector handshake; transfer when both are high on a posedge.
REQ-008 vec_scan_in  in  CHAIN_LEN  scan load pattern; bit CHAIN_LEN-1 is shifted first.
REQ-009 vec_pi  in  PI_W  PI value applied during this vector's capture.
REQ-010 exp_scan_out  in  CHAIN_LEN  expected captured chain state; bit CHAIN_LEN-1 is expected first on So.
REQ-011 exp_po  in  PO_W  expected PO value at capture.
REQ-012 vec_last  in  1  marks the final vector of the session.
REQ-013 NbarT  out  1  chain mode: 1 = shift, 0 = normal.
REQ-014 Si  out  1  scan data into chain cell 0.
REQ-015 CE  out  1  chain capture enable.
REQ-016 PI  out  PI_W  primary inputs to the circuit under test.
REQ-017 So  in  1  scan data out of chain cell CHAIN_LEN-1.
REQ-018 PO  in  PO_W  primary outputs of the circuit under test.
REQ-019 busy  out  1  session in progress.
REQ-020 done  out  1  one-cycle pulse at session end.
REQ-021 pass  out  1  valid from done until next start; 1 iff fail_count==0.
REQ-022 fail_count  out  16  number of failing vectors, saturating at 16'hFFFF.
REQ-023 first_fail  out  16  index of the first failing vector (0-based); 16'hFFFF if none.

Function
REQ-024 All outputs SHALL be registered; the chain samples NbarT/Si/CE/PI on the posedge after they change; So/PO are sampled on posedge C.
REQ-025 FSM states SHALL be IDLE, LOAD, SHIFT, CAPTURE, FLUSH, DONE.
REQ-026 IDLE: start=1 SHALL clear fail_count to 0, first_fail to 16'hFFFF and the vector index, then go to LOAD; start is ignored in all other states.
REQ-027 LOAD: vec_ready=1, NbarT=1, CE=0; on handshake all vector fields SHALL be latched and the state SHALL go to SHIFT.
REQ-028 SHIFT: exactly CHAIN_LEN cycles, NbarT=1, CE=0; cycle k (0-based) SHALL drive Si=vec_scan_in[CHAIN_LEN-1-k] and sample So.
REQ-029 While shifting in vector n>0, So sample k SHALL be compared with the expected bit CHAIN_LEN-1-k of vector n-1; for vector 0 the comparison is disabled.
REQ-030 CAPTURE: one cycle, NbarT=0, CE=1, PI=vec_pi; PO SHALL be compared with exp_po at that capture edge; next state is FLUSH if vec_last, else LOAD.
REQ-031 FLUSH: CHAIN_LEN cycles, NbarT=1, Si=0, comparing So against the last vector's expected scan bits as in SHIFT; then go to DONE.
REQ-032 A vector fails if any scan bit or PO bit mismatches; each failing vector SHALL increment fail_count once, and the first one SHALL set first_fail.
REQ-033 DONE: done=1 for one cycle, busy=0, then IDLE; pass/fail_count/first_fail are held until the next start.
REQ-034 busy SHALL be 1 in every state except IDLE and DONE.
REQ-035 PI SHALL hold its last value outside CAPTURE; Si=0 outside SHIFT.
REQ-036 A LOAD stall (vec_valid=0) SHALL hold chain mode NbarT=1 with CE=0 and no Si activity counted; the chain contents are preserved.
REQ-037 The vector index SHALL wrap at 16 bits; first_fail records the wrapped index.

Reset
REQ-038 global_reset_n=0 SHALL immediately force state IDLE, NbarT=0, Si=0, CE=0, PI=0, vec_ready=0, busy=0, done=0, pass=0, fail_count=0, first_fail=16'hFFFF, at any point including mid-shift; the chain contents are then undefined.

Verification
REQ-039 With CHAIN_LEN=4, PI_W=PO_W=2, a hold-chain model (D=Q, PO=PI), one vector 1010/pi 01/exp 1010/exp_po 01/last -> done 10 cycles after the handshake, pass=1, fail_count=0, first_fail=FFFF.
REQ-040 Same model, three vectors 1100, 0011, 1111, each expecting itself -> So sequences 1100, 0011, 1111 observed, pass=1.
REQ-041 So stuck at 0, two vectors expecting 0000 then 0110 -> fail_count=1, first_fail=1, pass=0.
REQ-042 PO forced to 11 with exp_po=01 on vector 0 of 2 -> fail_count=1, first_fail=0.
REQ-043 vec_valid held low for 5 cycles between vectors -> NbarT=1, CE=0 throughout the stall, and the result is identical to the unstalled run.
REQ-044 global_reset_n pulsed low during SHIFT cycle 2 -> all outputs take their reset values that cycle; a subsequent start runs a clean session.

Source files
------------

// File: rtl/scan_tester_if.sv
// scan_tester_if: vector handshake bundle between the pattern source (master) and scan_tester (slave).
interface scan_tester_if #(parameter int CHAIN_LEN = 8, parameter int PI_W = 4, parameter int PO_W = 4);
  logic                 vec_valid;
  logic                 vec_ready;
  logic                 vec_last;
  logic [CHAIN_LEN-1:0] vec_scan_in;
  logic [CHAIN_LEN-1:0] exp_scan_out;
  logic [PI_W-1:0]      vec_pi;
  logic [PO_W-1:0]      exp_po;
  modport master (output vec_valid, vec_last, vec_scan_in, exp_scan_out, vec_pi, exp_po, input vec_ready);
  modport slave (input vec_valid, vec_last, vec_scan_in, exp_scan_out, vec_pi, exp_po, output vec_ready);
endinterface

// File: rtl/scan_tester.sv
// scan_tester: drives a scan chain vector by vector (load, shift, capture, flush) and scores the unloaded response.
module scan_tester #(
  parameter int CHAIN_LEN = 8,
  parameter int PI_W      = 4,
  parameter int PO_W      = 4
) (
  input  logic             C,
  input  logic             global_reset_n,
  input  logic             start,
  scan_tester_if.slave     vif,
  output logic             NbarT,
  output logic             Si,
  output logic             CE,
  output logic [PI_W-1:0]  PI,
  input  logic             So,
  input  logic [PO_W-1:0]  PO,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      fail_count,
  output logic [15:0]      first_fail
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, FLUSH, DONE} state_t;
  localparam int KW = $clog2(CHAIN_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(CHAIN_LEN - 1);
  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [CHAIN_LEN-1:0] r_sin, r_exp_cur, r_exp_cmp;
  logic [PI_W-1:0]      r_vpi;
  logic [PO_W-1:0]      r_exp_po;
  logic [15:0]          r_idx;
  logic                 r_last, r_have, r_cmp, r_bad;
  logic                 w_bit_bad, w_vec_bad, w_k_last, w_fin;
  logic [15:0]          w_fail_idx;
  assign w_bit_bad  = So != r_exp_cmp[CHAIN_LEN-1];
  assign w_vec_bad  = r_bad | w_bit_bad;
  assign w_k_last   = r_k == K_LAST;
  // a vector is scored on the last unload bit: during the next vector's shift, or during flush for the final one
  assign w_fin      = w_k_last && w_vec_bad && (r_state == FLUSH || (r_state == SHIFT && r_cmp));
  assign w_fail_idx = r_state == FLUSH ? r_idx : r_idx - 16'd1;
  always_ff @(posedge C or negedge global_reset_n)
    if (!global_reset_n) begin
      r_state       <= IDLE;
      NbarT         <= 1'b0;
      Si            <= 1'b0;
      CE            <= 1'b0;
      PI            <= '0;
      vif.vec_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_count    <= '0;
      first_fail    <= '1;
      r_k           <= '0;
      r_sin         <= '0;
      r_exp_cur     <= '0;
      r_exp_cmp     <= '0;
      r_vpi         <= '0;
      r_exp_po      <= '0;
      r_idx         <= '0;
      r_last        <= 1'b0;
      r_have        <= 1'b0;
      r_cmp         <= 1'b0;
      r_bad         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_fin) begin
        fail_count <= fail_count == 16'hFFFF ? fail_count : fail_count + 16'd1;
        if (fail_count == '0) first_fail <= w_fail_idx;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state       <= LOAD;
          fail_count    <= '0;
          first_fail    <= '1;
          r_idx         <= '0;
          r_have        <= 1'b0;
          pass          <= 1'b0;
          busy          <= 1'b1;
          NbarT         <= 1'b1;
          vif.vec_ready <= 1'b1;
        end
        LOAD: if (vif.vec_valid) begin
          r_state       <= SHIFT;
          vif.vec_ready <= 1'b0;
          Si            <= vif.vec_scan_in[CHAIN_LEN-1];
          r_sin         <= vif.vec_scan_in << 1;
          r_vpi         <= vif.vec_pi;
          r_exp_po      <= vif.exp_po;
          r_last        <= vif.vec_last;
          r_exp_cur     <= vif.exp_scan_out;
          r_exp_cmp     <= r_exp_cur;
          r_cmp         <= r_have;
          r_have        <= 1'b1;
          r_idx         <= r_have ? r_idx + 16'd1 : r_idx;
          r_k           <= '0;
        end
        SHIFT: begin
          r_k       <= r_k + 1'b1;
          Si        <= r_sin[CHAIN_LEN-1];
          r_sin     <= r_sin << 1;
          r_exp_cmp <= r_exp_cmp << 1;
          r_bad     <= w_vec_bad;
          if (w_k_last) begin
            r_state <= CAPTURE;
            NbarT   <= 1'b0;
            CE      <= 1'b1;
            Si      <= 1'b0;
            PI      <= r_vpi;
          end
        end
        CAPTURE: begin
          CE    <= 1'b0;
          NbarT <= 1'b1;
          r_k   <= '0;
          r_bad <= PO != r_exp_po;
          if (r_last) begin
            r_state   <= FLUSH;
            r_exp_cmp <= r_exp_cur;
          end else begin
            r_state       <= LOAD;
            vif.vec_ready <= 1'b1;
          end
        end
        FLUSH: begin
          r_k       <= r_k + 1'b1;
          r_exp_cmp <= r_exp_cmp << 1;
          r_bad     <= w_vec_bad;
          if (w_k_last) begin
            r_state <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            NbarT   <= 1'b0;
            pass    <= fail_count == '0 && !w_vec_bad;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_scan_tester.sv
// tb_scan_tester: directed and randomized sessions against a hold-chain circuit model and a vector-level scoring model.
module tb_scan_tester;
  localparam int CL = 4, PW = 2, OW = 2;
  logic C = 1'b0, global_reset_n = 1'b0, start = 1'b0;
  logic NbarT, Si, CE, So, busy, done, pass;
  logic [PW-1:0] PI;
  logic [OW-1:0] PO;
  logic [15:0] fail_count, first_fail;
  scan_tester_if #(.CHAIN_LEN(CL), .PI_W(PW), .PO_W(OW)) vif ();
  scan_tester #(.CHAIN_LEN(CL), .PI_W(PW), .PO_W(OW)) dut (
    .C(C), .global_reset_n(global_reset_n), .start(start), .vif(vif),
    .NbarT(NbarT), .Si(Si), .CE(CE), .PI(PI), .So(So), .PO(PO),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count), .first_fail(first_fail));
  always #5 C = ~C;
  // circuit under test: chain holds its state on capture and only shifts while the tester is not waiting for a vector
  logic [CL-1:0] chain = '0;
  bit so_stuck = 0, po_force = 0;
  logic [OW-1:0] po_val = '0;
  always @(posedge C) if (NbarT && !vif.vec_ready) chain <= {chain[CL-2:0], Si};
  assign So = so_stuck ? 1'b0 : chain[CL-1];
  assign PO = po_force ? po_val : PI;
  bit mon = 0;
  logic so_q[$];
  logic [PW-1:0] pi_q[$];
  always @(negedge C) if (mon) begin
    if (NbarT && !vif.vec_ready && busy) so_q.push_back(So);
    if (CE) pi_q.push_back(PI);
  end
  logic [CL-1:0] vsi[8], vexp[8];
  logic [PW-1:0] vpi[8];
  logic [OW-1:0] vexpo[8];
  int stl[8];
  int npass = 0, ntot = 0;
  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s %s: observed %0h expected %0h", tag, what, obs, exp);
  endtask
  function automatic void model(input int n, output int fc, output int ff);
    logic [CL-1:0] got_s;
    logic [OW-1:0] got_p;
    fc = 0;
    ff = 'hFFFF;
    for (int v = 0; v < n; v++) begin
      got_s = so_stuck ? '0 : vsi[v];
      got_p = po_force ? po_val : vpi[v];
      if (got_s !== vexp[v] || got_p !== vexpo[v]) begin
        if (fc == 0) ff = v;
        fc++;
      end
    end
  endfunction
  task automatic session(input int n, input string tag);
    int fc, ff, lat, w;
    bit hs;
    logic [CL-1:0] s;
    so_q.delete();
    pi_q.delete();
    mon = 1;
    @(negedge C); start = 1;
    @(negedge C); start = 0;
    for (int v = 0; v < n; v++) begin
      int st = stl[v];
      hs = 0;
      w = 0;
      while (!hs && w < 400) begin
        if (st > 0) begin
          vif.vec_valid = 0;
          if (vif.vec_ready === 1'b1) begin
            chk(tag, "stall NbarT/CE", 32'({NbarT, CE}), 32'b10);
            st--;
          end
        end else begin
          vif.vec_valid = 1;
          vif.vec_scan_in = vsi[v];
          vif.vec_pi = vpi[v];
          vif.exp_scan_out = vexp[v];
          vif.exp_po = vexpo[v];
          vif.vec_last = v == n - 1;
          hs = vif.vec_ready === 1'b1;
        end
        w++;
        @(negedge C);
      end
      chk(tag, "handshake", 32'(hs), 32'd1);
      if (!hs) begin
        vif.vec_valid = 0;
        mon = 0;
        return;
      end
    end
    vif.vec_valid = 0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge C);
      lat++;
    end
    chk(tag, "done latency", 32'(lat), 32'(2 * CL + 2));
    model(n, fc, ff);
    chk(tag, "busy at done", 32'(busy), 32'd0);
    chk(tag, "pass", 32'(pass), 32'(fc == 0));
    chk(tag, "fail_count", 32'(fail_count), 32'(fc));
    chk(tag, "first_fail", 32'(first_fail), 32'(ff));
    @(negedge C);
    chk(tag, "done pulse end", 32'(done), 32'd0);
    chk(tag, "results held", 32'({pass, fail_count, first_fail}), 32'({fc == 0, 16'(fc), 16'(ff)}));
    mon = 0;
    chk(tag, "So bit count", 32'(so_q.size()), 32'(CL * (n + 1)));
    chk(tag, "capture count", 32'(pi_q.size()), 32'(n));
    if (so_q.size() == CL * (n + 1) && pi_q.size() == n)
      for (int v = 0; v < n; v++) begin
        for (int i = 0; i < CL; i++) s[CL-1-i] = so_q[CL * (v + 1) + i];
        chk(tag, $sformatf("So seq v%0d", v), 32'(s), 32'(so_stuck ? '0 : vsi[v]));
        chk(tag, $sformatf("PI at capture v%0d", v), 32'(pi_q[v]), 32'(vpi[v]));
      end
  endtask
  task automatic setv(input int v, input logic [CL-1:0] si, input logic [PW-1:0] p, input logic [CL-1:0] e, input logic [OW-1:0] ep, input int st);
    vsi[v] = si; vpi[v] = p; vexp[v] = e; vexpo[v] = ep; stl[v] = st;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    vif.vec_valid = 0; vif.vec_last = 0; vif.vec_scan_in = '0; vif.vec_pi = '0; vif.exp_scan_out = '0; vif.exp_po = '0;
    #12;
    chk("reset", "ctl bits", 32'({NbarT, Si, CE, vif.vec_ready, busy, done, pass}), 32'd0);
    chk("reset", "PI", 32'(PI), 32'd0);
    chk("reset", "fail_count", 32'(fail_count), 32'd0);
    chk("reset", "first_fail", 32'(first_fail), 32'hFFFF);
    @(negedge C); global_reset_n = 1;
    setv(0, 4'b1010, 2'b01, 4'b1010, 2'b01, 0);
    session(1, "single");
    setv(0, 4'b1100, 2'b10, 4'b1100, 2'b10, 0);
    setv(1, 4'b0011, 2'b01, 4'b0011, 2'b01, 0);
    setv(2, 4'b1111, 2'b11, 4'b1111, 2'b11, 0);
    session(3, "three");
    so_stuck = 1;
    setv(0, 4'b0000, 2'b00, 4'b0000, 2'b00, 0);
    setv(1, 4'b0110, 2'b01, 4'b0110, 2'b01, 0);
    session(2, "so_stuck");
    so_stuck = 0; po_force = 1; po_val = 2'b11;
    setv(0, 4'b0101, 2'b01, 4'b0101, 2'b01, 0);
    setv(1, 4'b1001, 2'b11, 4'b1001, 2'b11, 0);
    session(2, "po_forced");
    po_force = 0;
    setv(0, 4'b1100, 2'b10, 4'b1100, 2'b10, 0);
    setv(1, 4'b0011, 2'b01, 4'b0111, 2'b01, 0);
    setv(2, 4'b1111, 2'b11, 4'b1111, 2'b11, 0);
    session(3, "unstalled");
    stl[1] = 5;
    stl[2] = 5;
    session(3, "stalled");
    @(negedge C); start = 1;
    @(negedge C); start = 0;
    vif.vec_valid = 1; vif.vec_scan_in = 4'b1011; vif.vec_pi = 2'b10; vif.exp_scan_out = 4'b1011; vif.exp_po = 2'b10; vif.vec_last = 0;
    @(negedge C); vif.vec_valid = 0;
    @(negedge C);
    @(negedge C);
    chk("midreset", "mid-shift", 32'({busy, NbarT, vif.vec_ready}), 32'b110);
    #2 global_reset_n = 0;
    #1;
    chk("midreset", "ctl bits", 32'({NbarT, Si, CE, vif.vec_ready, busy, done, pass}), 32'd0);
    chk("midreset", "PI", 32'(PI), 32'd0);
    chk("midreset", "fail_count", 32'(fail_count), 32'd0);
    chk("midreset", "first_fail", 32'(first_fail), 32'hFFFF);
    @(negedge C); global_reset_n = 1;
    setv(0, 4'b1010, 2'b01, 4'b1010, 2'b01, 0);
    session(1, "after_reset");
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      so_stuck = $urandom_range(0, 5) == 0;
      po_force = $urandom_range(0, 3) == 0;
      po_val = OW'($urandom);
      for (int v = 0; v < n; v++) begin
        setv(v, CL'($urandom), PW'($urandom), '0, '0, $urandom_range(0, 3));
        vexp[v] = vsi[v];
        vexpo[v] = vpi[v];
        if ($urandom_range(0, 3) == 0) vexp[v][$urandom_range(0, CL - 1)] ^= 1'b1;
        if ($urandom_range(0, 4) == 0) vexpo[v][$urandom_range(0, OW - 1)] ^= 1'b1;
      end
      session(n, $sformatf("random%0d", r));
    end
    so_stuck = 0; po_force = 0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
